// File: rtl/div_sequencer.sv
// Multi-cycle integer divider: DIV/DIVU/REM/REMU using restoring radix-2
// division, one quotient bit per cycle, with fast paths for divide-by-zero
// and signed overflow.
//
// Handshake: a request is taken on a rising edge where start=1, busy=0 and
// at least one op_* bit is set; operands and op are captured on that edge
// and never looked at again. done is a one-cycle result-valid pulse with no
// back-pressure, and busy=0 during DONE so a new request can issue back to
// back.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic             op_divu,
  input  logic             op_rem,
  input  logic             op_remu,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state, state_nxt;
  // pending marks the cycle after accept, spent in IDLE choosing the path
  logic             pending;
  logic             is_signed, want_rem, sign_a, sign_b, dbz_r, ovf_r;
  logic [WIDTH-1:0] a_raw, mag_b, quo, rem;
  logic [CW-1:0]    count;

  logic             accept, acc_signed, acc_rem, dvd_neg, dvs_neg, acc_ovf;
  logic [WIDTH:0]   shifted, trial;
  logic             fits;
  logic [WIDTH-1:0] rem_nxt, quo_nxt, q_final, r_final, special;

  // Request decode with op_div > op_divu > op_rem > op_remu priority
  always_comb begin
    accept     = start & ~busy & (op_div | op_divu | op_rem | op_remu);
    acc_signed = op_div | (~op_divu & op_rem);
    acc_rem    = ~op_div & ~op_divu & (op_rem | op_remu);
    dvd_neg    = acc_signed & dividend[WIDTH-1];
    dvs_neg    = acc_signed & divisor[WIDTH-1];
    acc_ovf    = acc_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}})
                 && (divisor == {WIDTH{1'b1}});
  end

  // One restoring step, final sign fix and fast-path result
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, mag_b};
    fits    = ~trial[WIDTH];
    rem_nxt = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], fits};
    q_final = (is_signed & (sign_a ^ sign_b)) ? (~quo + 1'b1) : quo;
    r_final = (is_signed & sign_a) ? (~rem + 1'b1) : rem;
    if (dbz_r) special = want_rem ? a_raw : {WIDTH{1'b1}};
    else       special = want_rem ? {WIDTH{1'b0}} : a_raw;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt   = state;
    busy        = pending;
    done        = 1'b0;
    div_by_zero = 1'b0;
    case (state)
      IDLE: if (pending) state_nxt = (dbz_r | ovf_r) ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (count == '0) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        div_by_zero = dbz_r;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign state_dbg = state;

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending   <= 1'b0;
      is_signed <= 1'b0;
      want_rem  <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      dbz_r     <= 1'b0;
      ovf_r     <= 1'b0;
      a_raw     <= '0;
      mag_b     <= '0;
      quo       <= '0;
      rem       <= '0;
      count     <= '0;
      result    <= '0;
    end else begin
      pending <= accept;
      if (accept) begin
        is_signed <= acc_signed;
        want_rem  <= acc_rem;
        sign_a    <= dvd_neg;
        sign_b    <= dvs_neg;
        dbz_r     <= (divisor == '0);
        ovf_r     <= acc_ovf;
        a_raw     <= dividend;
        quo       <= dvd_neg ? (~dividend + 1'b1) : dividend;
        mag_b     <= dvs_neg ? (~divisor + 1'b1) : divisor;
        rem       <= '0;
        count     <= CW'(WIDTH - 1);
      end else if (state == CALC) begin
        rem   <= rem_nxt;
        quo   <= quo_nxt;
        count <= count - CW'(1);
      end
      if (state == IDLE && pending && (dbz_r | ovf_r))
        result <= special;
      else if (state == FIX)
        result <= want_rem ? r_final : q_final;
    end
  end

endmodule
